dm_access_ctrl: RTL and testbench

Sequencer between the MEM pipeline stage and a variable-latency data-memory bus. Accepts one load/store per MEM instruction and holds the pipeline with `stall` until the bus acknowledges. Generates byte enables and lane-replicated write data, then extracts and sign/zero-extends load data. Flags misaligned accesses and bus timeouts.

---
 rtl/dm_ctrl_pkg.sv | 39 +++
 rtl/dm_lane.sv | 81 ++++++++
 rtl/dm_access_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_dm_access_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared types and encodings for the data-memory access sequencer.
// Optional alignment checking is controlled by DM_ALIGN_CHECK_EN (see dm_lane).
package dm_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } dm_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } dm_size_e;

    localparam logic [2:0] MT_WORD = 3'b000;
    localparam logic [2:0] MT_BU   = 3'b001;
    localparam logic [2:0] MT_BS   = 3'b010;
    localparam logic [2:0] MT_HU   = 3'b011;
    localparam logic [2:0] MT_HS   = 3'b100;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_MIS_LD  = 2'b01;
    localparam logic [1:0] EXC_MIS_ST  = 2'b10;
    localparam logic [1:0] EXC_TIMEOUT = 2'b11;

    // Reserved type codes fall back to word accesses.
    function automatic dm_size_e decode_size(input logic [2:0] mtype);
        dm_size_e sz;
        case (mtype)
            MT_BU, MT_BS: sz = SZ_BYTE;
            MT_HU, MT_HS: sz = SZ_HALF;
            default:      sz = SZ_WORD;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/dm_lane.sv
// Combinational lane logic: store byte enables / replicated data, load extraction and extension.
// With DM_ALIGN_CHECK_EN defined it also reports misaligned half/word accesses.
module dm_lane
    import dm_ctrl_pkg::*;
(
    input  logic [2:0]  mem_type,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misaligned
);

    dm_size_e    size_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign size_s = decode_size(mem_type);

    // Store-side byte enables and lane replication.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata;
        case (size_s)
            SZ_BYTE: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be         = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata;
            end
        endcase
    end

    // Load-side lane selection and sign/zero extension.
    always_comb begin
        byte_s    = 8'h00;
        half_s    = 16'h0000;
        rdata_ext = rword;
        case (addr_lo)
            2'b00:   byte_s = rword[7:0];
            2'b01:   byte_s = rword[15:8];
            2'b10:   byte_s = rword[23:16];
            default: byte_s = rword[31:24];
        endcase
        if (addr_lo[1]) begin
            half_s = rword[31:16];
        end else begin
            half_s = rword[15:0];
        end
        case (mem_type)
            MT_BU:   rdata_ext = {24'h000000, byte_s};
            MT_BS:   rdata_ext = {{24{byte_s[7]}}, byte_s};
            MT_HU:   rdata_ext = {16'h0000, half_s};
            MT_HS:   rdata_ext = {{16{half_s[15]}}, half_s};
            default: rdata_ext = rword;
        endcase
    end

`ifdef DM_ALIGN_CHECK_EN
    // Half needs an even address, word needs a word-aligned address.
    always_comb begin
        misaligned = 1'b0;
        case (size_s)
            SZ_HALF: misaligned = addr_lo[0];
            SZ_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/dm_access_ctrl.sv
// Sequencer between the MEM stage and a variable-latency data-memory bus, with timeout.
// Misaligned-access exceptions exist only when DM_ALIGN_CHECK_EN is defined.
module dm_access_ctrl
    import dm_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [2:0]  mem_type,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        exc,
    output logic [1:0]  exc_code,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    dm_state_e   state_r, state_next_s;
    logic [7:0]  cnt_r;
    logic [2:0]  type_r;
    logic [1:0]  addr_lo_r;
    logic [31:0] rdata_r;
    logic        rdata_valid_r, exc_r, bus_req_r, bus_we_r;
    logic [1:0]  exc_code_r;
    logic [31:0] bus_addr_r, bus_wdata_r;
    logic [3:0]  bus_be_r;

    logic        stall_s, accept_s, misal_s, ack_s, tmo_s, timeout_hit_s;
    logic [2:0]  lane_type_s;
    logic [1:0]  lane_addr_s;
    logic [3:0]  lane_be_s;
    logic [31:0] lane_wdata_s, lane_rdata_s;
    logic        align_err_s;

    // In IDLE the lane sees the incoming request; afterwards the latched one.
    assign lane_type_s   = (state_r == ST_IDLE) ? mem_type      : type_r;
    assign lane_addr_s   = (state_r == ST_IDLE) ? mem_addr[1:0] : addr_lo_r;
    assign timeout_hit_s = (cnt_r == TIMEOUT_C);

    dm_lane u_lane (
        .mem_type   (lane_type_s),
        .addr_lo    (lane_addr_s),
        .wdata      (mem_wdata),
        .rword      (bus_rdata),
        .be         (lane_be_s),
        .wdata_lane (lane_wdata_s),
        .rdata_ext  (lane_rdata_s),
        .misaligned (align_err_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_valid) begin
                    state_next_s = align_err_s ? ST_DONE : ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus_ack || timeout_hit_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_DONE: state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode: stall plus the per-cycle events that drive the datapath.
    always_comb begin
        stall_s  = 1'b0;
        accept_s = 1'b0;
        misal_s  = 1'b0;
        ack_s    = 1'b0;
        tmo_s    = 1'b0;
        if (!reset) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    stall_s  = mem_valid;
                    accept_s = mem_valid & ~align_err_s;
                    misal_s  = mem_valid & align_err_s;
                end
                ST_REQ: begin
                    stall_s = 1'b1;
                    ack_s   = bus_ack;
                    tmo_s   = ~bus_ack & timeout_hit_s;
                end
                default: stall_s = 1'b0;
            endcase
        end
    end

    // Request latch, bus outputs, timeout counter and completion registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r         <= 8'h00;
            type_r        <= 3'b000;
            addr_lo_r     <= 2'b00;
            rdata_r       <= 32'h0000_0000;
            rdata_valid_r <= 1'b0;
            exc_r         <= 1'b0;
            exc_code_r    <= EXC_NONE;
            bus_req_r     <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= 32'h0000_0000;
            bus_be_r      <= 4'b0000;
            bus_wdata_r   <= 32'h0000_0000;
        end else begin
            rdata_valid_r <= ack_s | tmo_s | misal_s;
            exc_r         <= tmo_s | misal_s;
            if (tmo_s) begin
                exc_code_r <= EXC_TIMEOUT;
            end else if (misal_s) begin
                exc_code_r <= mem_we ? EXC_MIS_ST : EXC_MIS_LD;
            end else begin
                exc_code_r <= EXC_NONE;
            end
            rdata_r <= (ack_s && !bus_we_r) ? lane_rdata_s : 32'h0000_0000;

            if (accept_s) begin
                cnt_r       <= 8'h00;
                type_r      <= mem_type;
                addr_lo_r   <= mem_addr[1:0];
                bus_req_r   <= 1'b1;
                bus_we_r    <= mem_we;
                bus_addr_r  <= {mem_addr[31:2], 2'b00};
                bus_be_r    <= mem_we ? lane_be_s : 4'b0000;
                bus_wdata_r <= mem_we ? lane_wdata_s : 32'h0000_0000;
            end else if (ack_s || tmo_s) begin
                cnt_r       <= 8'h00;
                bus_req_r   <= 1'b0;
                bus_we_r    <= 1'b0;
                bus_addr_r  <= 32'h0000_0000;
                bus_be_r    <= 4'b0000;
                bus_wdata_r <= 32'h0000_0000;
            end else if (state_r == ST_REQ) begin
                cnt_r <= cnt_r + 8'h01;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign stall       = stall_s;
    assign rdata       = rdata_r;
    assign rdata_valid = rdata_valid_r;
    assign exc         = exc_r;
    assign exc_code    = exc_code_r;
    assign bus_req     = bus_req_r;
    assign bus_we      = bus_we_r;
    assign bus_addr    = bus_addr_r;
    assign bus_be      = bus_be_r;
    assign bus_wdata   = bus_wdata_r;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Scoreboard bench for dm_access_ctrl (TIMEOUT=4); expectations follow DM_ALIGN_CHECK_EN.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_valid = 1'b0, mem_we = 1'b0;
    logic [2:0]  mem_type = 3'b000;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
    logic        stall, rdata_valid, exc, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [1:0]  exc_code;
    logic [3:0]  bus_be;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        exc;
        logic [1:0]  code;
    } compl_t;

    compl_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    dm_access_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_we(mem_we),
        .mem_type(mem_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .exc(exc),
        .exc_code(exc_code), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every rdata_valid pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rdata_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_valid", 32'd1, 32'd0);
            end else begin
                compl_t e;
                e = sb_q.pop_front();
                check_val("sb_rdata", rdata, e.rdata);
                check_val("sb_exc", {31'd0, exc}, {31'd0, e.exc});
                check_val("sb_code", {30'd0, exc_code}, {30'd0, e.code});
            end
        end
    end

    task automatic idle(input int n);
        @(negedge clk);
        mem_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    // Drive one access; ack_at = REQ cycle number that acks (0 = never).
    task automatic run_txn(input string tag, input logic we, input logic [2:0] mt,
                           input logic [31:0] a, input logic [31:0] d, input int ack_at,
                           input logic [31:0] rword, input int exp_done, input logic exp_req,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rdata, input logic exp_exc,
                           input logic [1:0] exp_code);
        int   req_n = 0;
        int   stall_n = 0;
        logic saw_req = 1'b0;
        logic finished = 1'b0;
        compl_t e;
        @(negedge clk);
        mem_valid = 1'b1; mem_we = we; mem_type = mt; mem_addr = a; mem_wdata = d;
        e.rdata = exp_rdata; e.exc = exp_exc; e.code = exp_code;
        sb_q.push_back(e);
        for (int c = 0; c < 64 && !finished; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (stall) stall_n++;
            if (bus_req) begin
                req_n++;
                if (!saw_req) begin
                    saw_req = 1'b1;
                    check_val({tag, "_addr"}, bus_addr, {a[31:2], 2'b00});
                    check_val({tag, "_we"}, {31'd0, bus_we}, {31'd0, we});
                    check_val({tag, "_be"}, {28'd0, bus_be}, {28'd0, exp_be});
                    check_val({tag, "_wdata"}, bus_wdata, exp_wdata);
                end
                bus_rdata = rword;
                bus_ack   = (req_n == ack_at);
            end else begin
                bus_ack = 1'b0;
            end
            if (!stall) begin
                finished = 1'b1;
                check_val({tag, "_done_cyc"}, c, exp_done);
                check_val({tag, "_stall_cyc"}, stall_n, exp_done);
                check_val({tag, "_req_at_done"}, {31'd0, bus_req}, 32'd0);
            end
        end
        bus_ack = 1'b0;
        if (!finished) check_val({tag, "_bound"}, 32'd0, 32'd1);
        check_val({tag, "_saw_req"}, {31'd0, saw_req}, {31'd0, exp_req});
    endtask

    initial begin
        // Reset: outputs zero, stall forced low even with mem_valid high.
        mem_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check_val("rst_stall", {31'd0, stall}, 32'd0);
        check_val("rst_outs", {26'd0, bus_req, bus_we, rdata_valid, exc, exc_code}, 32'd0);
        check_val("rst_bus", bus_addr | bus_wdata | {28'd0, bus_be} | rdata, 32'd0);
        mem_valid = 1'b0;
        reset = 1'b1;
        idle(2);

        run_txn("lb", 1'b0, 3'b010, 32'h0000_1003, 32'h0, 1, 32'h80FF_1234, 2, 1'b1,
                4'b0000, 32'h0, 32'hFFFF_FF80, 1'b0, 2'b00);
        run_txn("sh", 1'b1, 3'b011, 32'h0000_2002, 32'h0000_BEEF, 3, 32'h0, 4, 1'b1,
                4'b1100, 32'hBEEF_BEEF, 32'h0, 1'b0, 2'b00);
`ifdef DM_ALIGN_CHECK_EN
        run_txn("lw_mis", 1'b0, 3'b000, 32'h0000_3001, 32'h0, 1, 32'h1234_5678, 1, 1'b0,
                4'b0000, 32'h0, 32'h0, 1'b1, 2'b01);
        run_txn("sh_mis", 1'b1, 3'b100, 32'h0000_7001, 32'h0000_1234, 1, 32'h0, 1, 1'b0,
                4'b0000, 32'h0, 32'h0, 1'b1, 2'b10);
`else
        run_txn("lw_mis", 1'b0, 3'b000, 32'h0000_3001, 32'h0, 1, 32'h1234_5678, 2, 1'b1,
                4'b0000, 32'h0, 32'h1234_5678, 1'b0, 2'b00);
        run_txn("sh_mis", 1'b1, 3'b100, 32'h0000_7001, 32'h0000_1234, 1, 32'h0, 2, 1'b1,
                4'b0011, 32'h1234_1234, 32'h0, 1'b0, 2'b00);
`endif
        run_txn("lhu_tmo", 1'b0, 3'b011, 32'h0000_4000, 32'h0, 0, 32'hDEAD_BEEF, 6, 1'b1,
                4'b0000, 32'h0, 32'h0, 1'b1, 2'b11);
        run_txn("lbu0", 1'b0, 3'b001, 32'h0000_0010, 32'h0, 1, 32'h0000_AB7F, 2, 1'b1,
                4'b0000, 32'h0, 32'h0000_007F, 1'b0, 2'b00);
        run_txn("lbu1", 1'b0, 3'b001, 32'h0000_0011, 32'h0, 1, 32'h0000_AB7F, 2, 1'b1,
                4'b0000, 32'h0, 32'h0000_00AB, 1'b0, 2'b00);
        run_txn("sb", 1'b1, 3'b001, 32'h0000_5001, 32'h0000_00A5, 2, 32'h0, 3, 1'b1,
                4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 2'b00);
        run_txn("lh", 1'b0, 3'b100, 32'h0000_6002, 32'h0, 2, 32'h8001_7FFF, 3, 1'b1,
                4'b0000, 32'h0, 32'hFFFF_8001, 1'b0, 2'b00);
        idle(2);

        // Reset during the second REQ cycle of a store; a late ack must be ignored.
        @(negedge clk);
        mem_valid = 1'b1; mem_we = 1'b1; mem_type = 3'b000;
        mem_addr = 32'h0000_8000; mem_wdata = 32'h1122_3344;
        #1 check_val("rr_stall0", {31'd0, stall}, 32'd1);
        @(negedge clk); #1;
        check_val("rr_req1", {31'd0, bus_req}, 32'd1);
        check_val("rr_wdata1", bus_wdata, 32'h1122_3344);
        @(negedge clk);
        reset = 1'b0;
        #1 check_val("rr_stall_forced", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1; mem_valid = 1'b0; bus_ack = 1'b1;
        #1;
        check_val("rr_outs", {26'd0, bus_req, bus_we, rdata_valid, exc, exc_code}, 32'd0);
        check_val("rr_bus", bus_addr | bus_wdata | {28'd0, bus_be} | rdata, 32'd0);
        check_val("rr_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1 check_val("rr_no_valid", {31'd0, rdata_valid}, 32'd0);
        @(negedge clk); #1;
        check_val("rr_no_valid2", {31'd0, rdata_valid}, 32'd0);
        check_val("rr_no_req", {31'd0, bus_req}, 32'd0);

        idle(3);
        check_val("sb_empty", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
